// File: rtl/mc_ctrl_pkg.sv
// Multicycle controller shared definitions: FSM state encoding, opcode values and
// datapath mux select encodings.
// Optional feature macro: MC_ILLEGAL_TRAP_EN adds the TRAP state for undefined opcodes.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    StFetch  = 5'd0,
    StDecode = 5'd1,
    StRAdd   = 5'd2,
    StRSub   = 5'd3,
    StWbAlu  = 5'd4,
    StWbSlt  = 5'd5,
    StWbEq   = 5'd6,
    StJal    = 5'd7,
    StJalr   = 5'd8,
    StJWb    = 5'd9,
    StMAddr  = 5'd10,
    StLwRd   = 5'd11,
    StSw     = 5'd12,
    StLwWb   = 5'd13,
    StAddiWb = 5'd14,
    StBneCmp = 5'd15,
    StBneTgt = 5'd16,
    StBneWb  = 5'd17,
    StILui   = 5'd18,
    StILli   = 5'd19,
    StIWb    = 5'd20
`ifdef MC_ILLEGAL_TRAP_EN
    , StTrap = 5'd21
`endif
  } state_e;

  localparam int unsigned OpcAdd  = 0;
  localparam int unsigned OpcSlt  = 1;
  localparam int unsigned OpcSub  = 2;
  localparam int unsigned OpcSeq  = 3;
  localparam int unsigned OpcJalr = 4;
  localparam int unsigned OpcLui  = 5;
  localparam int unsigned OpcJal  = 6;
  localparam int unsigned OpcAddi = 8;
  localparam int unsigned OpcLw   = 9;
  localparam int unsigned OpcSw   = 10;
  localparam int unsigned OpcBne  = 11;
  localparam int unsigned OpcLli  = 15;

  // ALU operand A select
  localparam logic [1:0] SrcAPc   = 2'd0;
  localparam logic [1:0] SrcAReg  = 2'd1;
  localparam logic [1:0] SrcAZero = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SrcBReg = 2'd0;
  localparam logic [1:0] SrcBTwo = 2'd1;
  localparam logic [1:0] SrcBImm = 2'd2;

  // Register write-back data select
  localparam logic [1:0] WbAluOut = 2'd0;
  localparam logic [1:0] WbMdr    = 2'd1;
  localparam logic [1:0] WbZero   = 2'd2;
  localparam logic [1:0] WbSign   = 2'd3;

endpackage

// File: rtl/mc_ctrl_opdec.sv
// Opcode dispatch decoder: maps the live opcode seen in DECODE to the first execute
// state and flags whether the opcode is defined. Purely combinational.
// Ports:
//   opcode_i  opcode field
//   target_o  state entered after DECODE (StFetch when the opcode is undefined)
//   legal_o   1 when the opcode is defined
module mc_ctrl_opdec
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode_i,
  output state_e           target_o,
  output logic             legal_o
);

  logic [31:0] opc;
  assign opc = 32'(opcode_i);

  always_comb begin
    target_o = StFetch;
    legal_o  = 1'b1;
    case (opc)
      OpcAdd:                 target_o = StRAdd;
      OpcSlt, OpcSub, OpcSeq: target_o = StRSub;
      OpcJalr:                target_o = StJalr;
      OpcJal:                 target_o = StJal;
      OpcLui:                 target_o = StILui;
      OpcLli:                 target_o = StILli;
      OpcAddi, OpcLw, OpcSw:  target_o = StMAddr;
      OpcBne:                 target_o = StBneCmp;
      default:                legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM. Sequences FETCH / DECODE / execute / write-back
// and drives the datapath strobes and mux selects from the current state; only the
// FETCH IRWrite/PCWrite strobes also depend on mem_ready.
// Optional feature macro: MC_ILLEGAL_TRAP_EN -- undefined opcodes enter a sticky TRAP
// state with illegal_op=1; otherwise they retire as a NOP and illegal_op is tied 0.
// Ports:
//   CLK, Reset        clock, synchronous active-high reset
//   inst              current IR contents, opcode at inst[OPC_LSB +: OPC_W]
//   mem_ready         pending memory read/write completes this cycle
//   PCWrite..ALUOp    1-bit datapath strobes/selects (ALUOp 0 add, 1 sub)
//   ALUSrcA/B, MemToReg  2-bit mux selects
//   illegal_op        undefined opcode trapped
//   state_dbg         encoded current state
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned INST_W  = 16,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned OPC_LSB = 0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [INST_W-1:0] inst,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              IorD,
  output logic              RegWrite,
  output logic              PCSrc,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              IRWrite,
  output logic              ALUOp,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        MemToReg,
  output logic              illegal_op,
  output logic [4:0]        state_dbg
);

  state_e           state_q;
  logic [OPC_W-1:0] opc_q;
  logic [OPC_W-1:0] opc_live;
  logic [31:0]      opc_q_ext;
  state_e           dec_target;
  logic             dec_legal;

  assign opc_live  = inst[OPC_LSB +: OPC_W];
  assign opc_q_ext = 32'(opc_q);

  // Only the opcode field matters; fold the rest so the whole word counts as used.
  logic unused_inst;
  assign unused_inst = ^inst;

  mc_ctrl_opdec #(
    .OPC_W (OPC_W)
  ) u_opdec (
    .opcode_i (opc_live),
    .target_o (dec_target),
    .legal_o  (dec_legal)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  logic trap_q;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StFetch;
      opc_q   <= '0;
`ifdef MC_ILLEGAL_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StFetch:  if (mem_ready) state_q <= StDecode;
        StDecode: begin
          opc_q <= opc_live;
          if (dec_legal) begin
            state_q <= dec_target;
          end else begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_q <= StTrap;
            trap_q  <= 1'b1;
`else
            state_q <= StFetch;
`endif
          end
        end
        StRAdd:   state_q <= StWbAlu;
        // Later branching uses the registered opcode; IR may already be changing.
        StRSub: begin
          case (opc_q_ext)
            OpcSlt:  state_q <= StWbSlt;
            OpcSeq:  state_q <= StWbEq;
            default: state_q <= StWbAlu;
          endcase
        end
        StMAddr: begin
          case (opc_q_ext)
            OpcLw:   state_q <= StLwRd;
            OpcSw:   state_q <= StSw;
            default: state_q <= StAddiWb;
          endcase
        end
        StLwRd:   if (mem_ready) state_q <= StLwWb;
        StSw:     if (mem_ready) state_q <= StFetch;
        StJal,
        StJalr:   state_q <= StJWb;
        StBneCmp: state_q <= StBneTgt;
        StBneTgt: state_q <= StBneWb;
        StILui,
        StILli:   state_q <= StIWb;
        StWbAlu, StWbSlt, StWbEq, StJWb, StLwWb, StAddiWb, StBneWb, StIWb:
          state_q <= StFetch;
`ifdef MC_ILLEGAL_TRAP_EN
        StTrap:   state_q <= StTrap;
`endif
        default:  state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    PCSrc       = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    ALUOp       = 1'b0;
    ALUSrcA     = SrcAPc;
    ALUSrcB     = SrcBReg;
    MemToReg    = WbAluOut;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = SrcBTwo;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StRAdd:   ALUSrcA = SrcAReg;
      StRSub, StBneCmp: begin
        ALUSrcA = SrcAReg;
        ALUOp   = 1'b1;
      end
      StWbAlu, StAddiWb, StIWb: RegWrite = 1'b1;
      StWbSlt: begin
        RegWrite = 1'b1;
        MemToReg = WbSign;
      end
      StWbEq: begin
        RegWrite = 1'b1;
        MemToReg = WbZero;
      end
      StJal, StMAddr: begin
        ALUSrcA = SrcAReg;
        ALUSrcB = SrcBImm;
      end
      StJalr:   IRWrite = 1'b1;
      StJWb:    PCWrite = 1'b1;
      StLwRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StSw: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StLwWb: begin
        RegWrite = 1'b1;
        MemToReg = WbMdr;
      end
      StBneTgt, StILui, StILli: begin
        ALUSrcA = SrcAZero;
        ALUSrcB = SrcBImm;
      end
      StBneWb: begin
        PCSrc       = 1'b1;
        PCWriteCond = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = trap_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each cycle's stimulus and its expected state
// and outputs are queued up front, then replayed one cycle at a time against the DUT.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic        CLK;
  logic        Reset;
  logic [15:0] inst;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, RegWrite, PCSrc, MemWrite, MemRead, IRWrite, ALUOp;
  logic [1:0]  ALUSrcA, ALUSrcB, MemToReg;
  logic        illegal_op;
  logic [4:0]  state_dbg;

  multicycle_ctrl #(
    .INST_W  (16),
    .OPC_W   (4),
    .OPC_LSB (0)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .inst        (inst),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .RegWrite    (RegWrite),
    .PCSrc       (PCSrc),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .IRWrite     (IRWrite),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .MemToReg    (MemToReg),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] outs;
  assign outs = {PCWrite, PCWriteCond, IorD, RegWrite, PCSrc, MemWrite, MemRead, IRWrite,
                 ALUOp, ALUSrcA, ALUSrcB, MemToReg, illegal_op};

  typedef struct packed {
    int unsigned id;
    logic        rst;
    logic        mr;
    logic [15:0] inst;
    logic [4:0]  st;
    logic [15:0] out;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected strobes per state, straight from the state/output table.
  function automatic logic [15:0] model(input state_e s, input logic mr);
    logic pcw = 0, pcwc = 0, iord = 0, rw = 0, pcsrc = 0, mwr = 0, mrd = 0, irw = 0;
    logic aop = 0, ill = 0;
    logic [1:0] sa = 0, sbs = 0, m2r = 0;
    case (s)
      StFetch:  begin mrd = 1; sbs = 2'd1; irw = mr; pcw = mr; end
      StRAdd:   sa = 2'd1;
      StRSub:   begin sa = 2'd1; aop = 1; end
      StWbAlu:  rw = 1;
      StWbSlt:  begin rw = 1; m2r = 2'd3; end
      StWbEq:   begin rw = 1; m2r = 2'd2; end
      StJal:    begin sa = 2'd1; sbs = 2'd2; end
      StJalr:   irw = 1;
      StJWb:    pcw = 1;
      StMAddr:  begin sa = 2'd1; sbs = 2'd2; end
      StLwRd:   begin iord = 1; mrd = 1; end
      StSw:     begin iord = 1; mwr = 1; end
      StLwWb:   begin rw = 1; m2r = 2'd1; end
      StAddiWb: rw = 1;
      StBneCmp: begin sa = 2'd1; aop = 1; end
      StBneTgt: begin sa = 2'd2; sbs = 2'd2; end
      StBneWb:  begin pcsrc = 1; pcwc = 1; end
      StILui:   begin sa = 2'd2; sbs = 2'd2; end
      StILli:   begin sa = 2'd2; sbs = 2'd2; end
      StIWb:    rw = 1;
`ifdef MC_ILLEGAL_TRAP_EN
      StTrap:   ill = 1;
`endif
      default: ;
    endcase
    return {pcw, pcwc, iord, rw, pcsrc, mwr, mrd, irw, aop, sa, sbs, m2r, ill};
  endfunction

  task automatic push(input int unsigned id, input logic rst, input logic mr,
                      input logic [3:0] op, input state_e st);
    item_t it;
    it.id   = id;
    it.rst  = rst;
    it.mr   = mr;
    it.inst = {12'hA5C, op};
    it.st   = st;
    it.out  = model(st, mr);
    sb.push_back(it);
  endtask

  // Short no-stall instruction: FETCH, DECODE, then the given execute states.
  task automatic push_simple(input int unsigned id, input logic [3:0] op,
                             input state_e s2, input state_e s3);
    push(id, 0, 1, op, StFetch);
    push(id, 0, 0, op, StDecode);
    push(id, 0, 1, op, s2);
    push(id, 0, 0, op, s3);
  endtask

  task automatic run_sb();
    item_t it;
    while (sb.size() > 0) begin
      it        = sb.pop_front();
      Reset     = it.rst;
      mem_ready = it.mr;
      inst      = it.inst;
      @(negedge CLK);
      check_eq($sformatf("t%0d_state", it.id), 32'(state_dbg), 32'(it.st));
      check_eq($sformatf("t%0d_outs", it.id), 32'(outs), 32'(it.out));
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    Reset     = 1'b1;
    mem_ready = 1'b1;
    inst      = 16'hFFF9;
    repeat (2) @(posedge CLK);
    #1;

    // Cycle after reset, no memory completion: only MemRead/ALUSrcB
    push(1, 0, 0, 4'd0, StFetch);
    // ADD, no stalls
    push_simple(2, 4'd0, StRAdd, StWbAlu);
    // Two FETCH stalls, then LUI
    push(3, 0, 0, 4'd5, StFetch);
    push(3, 0, 0, 4'd5, StFetch);
    push(3, 0, 1, 4'd5, StFetch);
    push(3, 0, 0, 4'd5, StDecode);
    push(3, 0, 1, 4'd5, StILui);
    push(3, 0, 0, 4'd5, StIWb);
    // LW with three memory stalls
    push(4, 0, 1, 4'd9, StFetch);
    push(4, 0, 0, 4'd9, StDecode);
    push(4, 0, 0, 4'd9, StMAddr);
    push(4, 0, 0, 4'd9, StLwRd);
    push(4, 0, 0, 4'd9, StLwRd);
    push(4, 0, 0, 4'd9, StLwRd);
    push(4, 0, 1, 4'd9, StLwRd);
    push(4, 0, 0, 4'd9, StLwWb);
    // BNE
    push(5, 0, 1, 4'd11, StFetch);
    push(5, 0, 1, 4'd11, StDecode);
    push(5, 0, 1, 4'd11, StBneCmp);
    push(5, 0, 1, 4'd11, StBneTgt);
    push(5, 0, 1, 4'd11, StBneWb);
    // SLT; IR changes to opcode 3 after DECODE, registered opcode must win
    push(6, 0, 1, 4'd1, StFetch);
    push(6, 0, 0, 4'd1, StDecode);
    push(6, 0, 1, 4'd3, StRSub);
    push(6, 0, 0, 4'd3, StWbSlt);
    push_simple(7, 4'd2, StRSub, StWbAlu);
    push_simple(8, 4'd3, StRSub, StWbEq);
    push_simple(9, 4'd6, StJal, StJWb);
    push_simple(10, 4'd4, StJalr, StJWb);
    push_simple(11, 4'd8, StMAddr, StAddiWb);
    push_simple(12, 4'd15, StILli, StIWb);
    // SW with one stall
    push(13, 0, 1, 4'd10, StFetch);
    push(13, 0, 1, 4'd10, StDecode);
    push(13, 0, 1, 4'd10, StMAddr);
    push(13, 0, 0, 4'd10, StSw);
    push(13, 0, 1, 4'd10, StSw);
    // Undefined opcode 7
    push(14, 0, 1, 4'd7, StFetch);
    push(14, 0, 1, 4'd7, StDecode);
`ifdef MC_ILLEGAL_TRAP_EN
    push(14, 0, 1, 4'd0, StTrap);
    push(14, 0, 1, 4'd0, StTrap);
    push(14, 1, 1, 4'd0, StTrap);
`endif
    // Reset during a stalled SW aborts it
    push(15, 0, 1, 4'd10, StFetch);
    push(15, 0, 1, 4'd10, StDecode);
    push(15, 0, 1, 4'd10, StMAddr);
    push(15, 0, 0, 4'd10, StSw);
    push(15, 1, 0, 4'd10, StSw);
    push(15, 0, 0, 4'd0, StFetch);
    push_simple(16, 4'd0, StRAdd, StWbAlu);
    push(16, 0, 0, 4'd0, StFetch);

    run_sb();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter INST_W, default 16, instruction width in bits.
REQ-002 Parameter OPC_W, default 4, opcode field width.
REQ-003 Parameter OPC_LSB, default 0, bit position of opcode LSB within inst.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 inst  in  INST_W  current IR contents.
REQ-007 mem_ready  in  1  memory completes the pending read/write this cycle.
REQ-008 PCWrite, PCWriteCond, IorD, RegWrite, PCSrc, MemWrite, MemRead, IRWrite, ALUOp  out  1 each  datapath strobes/selects (ALUOp 0 = add, 1 = sub).
REQ-009 ALUSrcA, ALUSrcB, MemToReg  out  2 each  mux selects (A: 0 PC, 1 A, 2 zero; B: 0 B, 1 const 2, 2 imm; MemToReg: 0 ALUOut, 1 MDR, 2 zero-flag, 3 sign-flag).
REQ-010 illegal_op  out  1  undefined opcode trapped.
REQ-011 state_dbg  out  5  encoded current state.

Function
REQ-012 Outputs SHALL be decoded from current state only, except the mem_ready-gated strobes in REQ-014/REQ-019; every output not listed for a state SHALL be 0.
REQ-013 Opcode SHALL be inst[OPC_LSB+OPC_W-1:OPC_LSB], captured into an opcode register on the DECODE cycle; all post-DECODE branching SHALL use the register.
REQ-014 FETCH: MemRead=1, ALUSrcB=1; IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-015 DECODE dispatch: 0 -> R_ADD; 1, 2, 3 -> R_SUB; 4 -> JALR; 6 -> JAL; 5 -> I_LUI; 15 -> I_LLI; 8, 9, 10 -> M_ADDR; 11 -> BNE_CMP; any other -> per REQ-025.
REQ-016 R_ADD (ALUSrcA=1) -> WB_ALU; R_SUB (ALUSrcA=1, ALUOp=1) -> opcode 1: WB_SLT, 2: WB_ALU, 3: WB_EQ.
REQ-017 WB_ALU RegWrite=1; WB_SLT RegWrite=1, MemToReg=3; WB_EQ RegWrite=1, MemToReg=2; each -> FETCH.
REQ-018 JAL (ALUSrcA=1, ALUSrcB=2) -> J_WB; JALR (IRWrite=1) -> J_WB; J_WB (PCWrite=1) -> FETCH.
REQ-019 M_ADDR (ALUSrcA=1, ALUSrcB=2) -> opcode 8: ADDI_WB, 9: LW_RD, 10: SW; LW_RD (IorD=1, MemRead=1) and SW (IorD=1, MemWrite=1) SHALL hold until mem_ready=1, then LW_RD -> LW_WB, SW -> FETCH.
REQ-020 LW_WB RegWrite=1, MemToReg=1; ADDI_WB RegWrite=1; each -> FETCH.
REQ-021 BNE_CMP (ALUSrcA=1, ALUOp=1) -> BNE_TGT (ALUSrcA=2, ALUSrcB=2) -> BNE_WB (PCSrc=1, PCWriteCond=1) -> FETCH.
REQ-022 I_LUI and I_LLI (ALUSrcA=2, ALUSrcB=2) -> I_WB (RegWrite=1) -> FETCH.
REQ-023 Latency without stalls: FETCH+DECODE+ALU/JAL=4 cycles, LW=5, BNE=5, SW=4; each mem_ready=0 cycle adds one.
REQ-024 Unreachable state encodings SHALL go to FETCH on the next edge with all strobes 0.
REQ-025 Undefined opcode: behaviour per REQ-029/REQ-030.

Reset
REQ-026 Reset=1 at an edge SHALL force state FETCH, opcode register 0, trap flag 0, regardless of current state or mem_ready (aborts stalled accesses).
REQ-027 Cycle after reset: MemRead=1, ALUSrcB=1, illegal_op=0, all writes 0 unless mem_ready=1.

Configuration
REQ-028 Macro MC_ILLEGAL_TRAP_EN selects illegal-opcode handling.
REQ-029 Defined: undefined opcode -> TRAP state, all strobes 0, illegal_op=1, held until Reset.
REQ-030 Undefined: undefined opcode -> FETCH (executes as NOP); TRAP absent; illegal_op tied 0.

Structure
REQ-031 Package mc_ctrl_pkg SHALL hold the state enum, opcode constants, and ALUSrcA/ALUSrcB/MemToReg encodings.
REQ-032 Sub-module mc_ctrl_opdec SHALL map opcode to DECODE dispatch target and legal flag combinationally.

Verification
REQ-033 Reset, mem_ready=1, inst opcode 0 -> FETCH, DECODE, R_ADD, WB_ALU; RegWrite=1 in cycle 4 only, back to FETCH.
REQ-034 Opcode 9, mem_ready=0 for 3 cycles in LW_RD -> LW_RD held 3 cycles, IorD=MemRead=1, then LW_WB with MemToReg=1, RegWrite=1.
REQ-035 mem_ready=0 for 2 FETCH cycles -> IRWrite/PCWrite stay 0, then asserted in the single mem_ready=1 cycle.
REQ-036 Opcode 11 -> PCWriteCond=1, PCSrc=1 only in 5th cycle.
REQ-037 Opcode 7 -> with MC_ILLEGAL_TRAP_EN: illegal_op=1 held; without: FETCH after DECODE, illegal_op=0.
REQ-038 Reset asserted mid-SW stall -> FETCH on next edge, MemWrite=0.
